// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg
// Shared definitions for the RV64I instruction/immediate packer:
//   - opcode constants for every opcode the packer understands
//   - imm_fmt_t : immediate format selected from the opcode
//   - err_t     : 2-bit result code carried with every output beat
//   - state_t   : run/halt state of the handshake controller
//   - sext_ok() : "all bits above lsb equal bit lsb" range test
package rv_imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_SB,
        FMT_U,
        FMT_UJ,
        FMT_NONE
    } imm_fmt_t;

    typedef logic [1:0] err_t;

    localparam err_t ERR_OK     = 2'b00;
    localparam err_t ERR_OPCODE = 2'b01;
    localparam err_t ERR_RANGE  = 2'b10;
    localparam err_t ERR_ALIGN  = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    // True when every bit above 'lsb' repeats bit 'lsb', i.e. the value
    // fits a signed field whose sign bit sits at position 'lsb'.
    function automatic logic sext_ok(input logic [63:0] value, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i > lsb && value[i] != value[lsb]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_fmt_pack.sv
// imm_fmt_pack
// Purely combinational core of the packer: picks the immediate format
// from the opcode, validates range and alignment of the immediate and
// scatters immediate and register fields into a 32-bit instruction.
// Ports:
//   opcode, funct3, rd, rs1, rs2 : decoded instruction fields
//   imm                          : 64-bit sign-extended immediate
//   inst                         : packed instruction, 0 whenever err != ok
//   err                          : 00 ok, 01 opcode, 10 range, 11 alignment
module imm_fmt_pack
    import rv_imm_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] inst,
    output logic [1:0]  err
);

    imm_fmt_t    fmt;
    logic        range_ok;
    logic        misaligned;
    logic [31:0] packed_inst;

    // JALR shares its opcode with the branch-style encoding: funct3 = 000
    // is the real JALR (I format), anything else is packed as SB.
    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OP_IMM, OP_LOAD: fmt = FMT_I;
            OP_JALR:         fmt = (funct3 == 3'b000) ? FMT_I : FMT_SB;
            OP_STORE:        fmt = FMT_S;
            OP_BRANCH:       fmt = FMT_SB;
            OP_LUI:          fmt = FMT_U;
            OP_JAL:          fmt = FMT_UJ;
            default:         fmt = FMT_NONE;
        endcase
    end

    // U immediates must also have a clear low 12 bits, otherwise the
    // extractor could not return the same value.
    always_comb begin
        range_ok = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_ok = sext_ok(imm, 11);
            FMT_SB:       range_ok = sext_ok(imm, 12);
            FMT_UJ:       range_ok = sext_ok(imm, 20);
            FMT_U:        range_ok = sext_ok(imm, 31) && (imm[11:0] == 12'd0);
            default:      range_ok = 1'b0;
        endcase
        misaligned = ((fmt == FMT_SB) || (fmt == FMT_UJ)) && imm[0];
    end

    // Priority: unknown opcode, then misalignment, then range.
    always_comb begin
        if (fmt == FMT_NONE) begin
            err = ERR_OPCODE;
        end else if (misaligned) begin
            err = ERR_ALIGN;
        end else if (!range_ok) begin
            err = ERR_RANGE;
        end else begin
            err = ERR_OK;
        end
    end

    always_comb begin
        packed_inst = 32'd0;
        case (fmt)
            FMT_I:   packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SB:  packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                                    imm[4:1], imm[11], opcode};
            FMT_U:   packed_inst = {imm[31:12], rd, opcode};
            FMT_UJ:  packed_inst = {imm[20], imm[10:1], imm[11], imm[19:12],
                                    rd, opcode};
            default: packed_inst = 32'd0;
        endcase
        inst = (err == ERR_OK) ? packed_inst : 32'd0;
    end

endmodule

// File: rtl/inst_imm_packer.sv
// inst_imm_packer
// RV64I instruction encoder with valid/ready request and result ports.
// One registered output stage holds the packed word and its error code
// until the consumer takes it. Counters track accepted good and errored
// requests; with STOP_ON_ERR set, an errored request halts intake until
// clear_err is pulsed.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake
//   in_opcode .. in_imm   : request fields
//   clear_err             : pulse that leaves the halted state
//   out_valid / out_ready : result handshake
//   out_inst, out_err     : packed instruction and error code
//   halted                : controller is in HALT
//   enc_count, err_count  : accepted good / errored requests (wrapping)
module inst_imm_packer
    import rv_imm_pkg::*;
#(
    parameter bit STOP_ON_ERR = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    input  logic             clear_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [1:0]       out_err,
    output logic             halted,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    state_t      state;
    state_t      state_next;
    logic [31:0] pack_inst;
    logic [1:0]  pack_err;
    logic        accept;

    imm_fmt_pack u_pack (
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .inst   (pack_inst),
        .err    (pack_err)
    );

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Intake is closed while halted, so an accept and clear_err can never
    // race in HALT; clear_err seen in RUN is simply ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (STOP_ON_ERR && accept && (pack_err != ERR_OK)) state_next = ST_HALT;
            ST_HALT: if (clear_err) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // A new request may enter when the output slot is empty or is being
    // emptied on this same edge.
    always_comb begin
        in_ready = (state == ST_RUN) && (!out_valid || out_ready);
        halted   = (state == ST_HALT);
    end

    // Output stage: a simultaneous take and accept just overwrites the slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_err   <= ERR_OK;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= pack_inst;
            out_err   <= pack_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Counters follow acceptance, not delivery, and wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (accept) begin
            if (pack_err == ERR_OK) begin
                enc_count <= enc_count + CNT_W'(1);
            end else begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/inst_imm_packer.md
# inst_imm_packer

Instruction encoder for the RV64I immediate formats. It takes decoded fields (opcode, funct3, register indices) plus a 64-bit sign-extended immediate and packs them into a 32-bit instruction word. It is the inverse of the core's immediate extractor, and is used by the boot/test loader path and the self-check harness. Every packed word, fed back through the extractor, must yield the original immediate. Requests and results use valid/ready handshakes, with one registered output stage, range/alignment checking, error counters and an optional halt-on-error state machine.

## Interface
- `STOP_ON_ERR`, 0: when 1, any errored request halts the block until `clear_err`.
- `CNT_W`, 16: width of the encoded/error counters.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted when `in_valid && in_ready` at a rising edge.
- `in_opcode` input 7: instruction opcode.
- `in_funct3` input 3: funct3 field.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register fields.
- `in_imm` input 64: immediate, as the extractor would produce it.
- `clear_err` input 1: single-cycle pulse; leaves HALT.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: consumer takes the beat when `out_valid && out_ready`.
- `out_inst` output 32: packed instruction, or 0 on error.
- `out_err` output 2: 00 ok, 01 bad opcode, 10 immediate out of range, 11 misaligned.
- `halted` output 1: FSM is in HALT.
- `enc_count` output CNT_W: accepted beats with `err==00`; wraps.
- `err_count` output CNT_W: accepted beats with `err!=00`; wraps.

## Operation
- **Format select by opcode:**
  - I format: 0010011, 0000011, and 1100111 with funct3=000 (JALR).
  - S format: 0100011.
  - SB format: 1100011, and 1100111 with funct3≠000.
  - U format: 0110111.
  - UJ format: 1101111.
  - Any other opcode is error 01.
- **Packing:** the immediate bit placement is the exact inverse of the extractor.
  - I: `imm[11:0]`→[31:20].
  - S: `imm[11:5]`→[31:25], `imm[4:0]`→[11:7].
  - SB: `imm[12]`→[31], `imm[10:5]`→[30:25], `imm[4:1]`→[11:8], `imm[11]`→[7].
  - U: `imm[31:12]`→[31:12].
  - UJ: `imm[20]`→[31], `imm[10:1]`→[30:21], `imm[11]`→[20], `imm[19:12]`→[19:12].
  - Field placement: rd→[11:7] for I/U/UJ; funct3→[14:12] for I/S/SB; rs1→[19:15] for I/S/SB; rs2→[24:20] for S/SB; opcode→[6:0].
- **Range checks:** "sign-ext" means all higher bits equal the named bit.
  - I and S: `imm[63:11]` is sign-ext, i.e. −2048..2047.
  - SB: `imm[63:12]` is sign-ext.
  - UJ: `imm[63:20]` is sign-ext.
  - U: `imm[63:31]` is sign-ext and `imm[11:0]` = 0; nonzero low bits are error 10.
- **Alignment:** SB/UJ with `imm[0]`=1 is error 11.
- **Error priority:** 01 > 11 > 10.
- **Error beats:** an errored request still produces one output beat, with `out_inst`=0 and the error code.
- **FSM states:**
  - RUN: `in_ready = !out_valid || out_ready`.
  - HALT: `in_ready`=0.
  - RUN→HALT on accepting an errored beat when `STOP_ON_ERR`=1.
  - HALT→RUN on `clear_err`=1. `clear_err` in RUN is ignored.
  - The errored beat itself is still delivered while halted.
- **Counters:** increment on accept, not on delivery. Both wrap at 2^CNT_W.

## Timing
- **Reset values:** `out_valid`=0, `out_inst`=0, `out_err`=00, FSM=RUN, `halted`=0, both counters 0. `in_ready` is combinational and 1 after reset.
- **Latency:** a request accepted at edge N appears on `out_*` after edge N and holds until taken.
- **Throughput:** one beat per cycle when `out_ready`=1. A simultaneous take and accept replaces the register in the same edge.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0, `in_ready`=0 and `out_*` stays stable.
- **`clear_err` with a pending accept:** `clear_err` in the same cycle as HALT entry has no effect, because the entry wins.
- **Reset mid-operation:** reset drops any pending output beat and returns the FSM to RUN with counters cleared, regardless of the handshake signals.

## Structure
- **Shared package `rv_imm_pkg`:**
  - Opcode constants: OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_JAL.
  - `imm_fmt_t` enum: I, S, SB, U, UJ, NONE.
  - Error code constants.
- **Sub-module `imm_fmt_pack`:** combinational; format select, range/alignment check and bit packing.
- **Top level:** handshake register, FSM and counters.

## Test plan
- **I format:** opcode 0010011, f3=0, rd=1, rs1=0, imm=64'hFFFF_FFFF_FFFF_FFFF → `out_inst`=32'hFFF00093, err 00, `enc_count`=1.
- **S format:** opcode 0100011, f3=011, rs1=2, rs2=5, imm=8 → 32'h00513423.
- **SB format and errors:**
  - opcode 1100011, f3=000, rs1=rs2=0, imm=−4 → 32'hFE000EE3.
  - imm=3 → err 11, inst 0.
  - imm=4096 → err 10.
  - opcode 0110011 → err 01.
  - `err_count`=3 after the three error cases.
- **U format:**
  - opcode 0110111, rd=1, imm=64'h12345000 → 32'h123450B7.
  - imm=64'h0000_0000_8000_0000 → err 10.
- **Backpressure and round trip:**
  - Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_*` unchanged; release → one beat per cycle.
  - Random legal requests → extractor(`out_inst`) == `in_imm`.
- **Halt and reset:**
  - `STOP_ON_ERR`=1, errored beat → `halted`=1, `in_ready`=0 until the `clear_err` pulse, then RUN.
  - `reset` with `out_valid`=1 → `out_valid`=0 and counters 0 on the next cycle.
